// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared matrix-datapath widths and row vector type
package mm_pkg;

  localparam int MM_BITS_C = 24;
  localparam int MM_DIM    = 8;
  localparam int ROW_W     = $clog2(MM_DIM);

  typedef logic signed [MM_BITS_C-1:0] elem_t;
  typedef elem_t [MM_DIM-1:0]          row_t;
  typedef logic [ROW_W-1:0]            row_idx_t;

endpackage

// File: rtl/skew_delay.sv
// rtl/skew_delay.sv - fixed-depth shift register, STAGES=0 is a combinational pass
module skew_delay #(
  parameter int BITS_C = 24,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_C-1:0] d_i,
  output logic [BITS_C-1:0] q_o
);

  // At least one stage is always declared; the output mux bypasses it when STAGES=0.
  localparam int N = (STAGES == 0) ? 1 : STAGES;

  logic [BITS_C-1:0] sr_q [N];
  logic [BITS_C-1:0] sr_d [N];

  always_comb begin
    sr_d[0] = d_i;
    for (int i = 1; i < N; i++) sr_d[i] = sr_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sr_q[i] <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = (STAGES == 0) ? d_i : sr_q[N-1];

endmodule

// File: rtl/memc_deskew.sv
// rtl/memc_deskew.sv - realigns the skewed array output lanes into rows
// and buffers them in a DIM-deep tagged FIFO for host readback.
module memc_deskew
  import mm_pkg::*;
#(
  parameter int BITS_C = MM_BITS_C,
  parameter int DIM    = MM_DIM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DIM-1:0][BITS_C-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DIM-1:0][BITS_C-1:0]  out_data,
  output logic [$clog2(DIM)-1:0]      out_row,
  output logic                        done,
  output logic                        overflow
);

  localparam int AW = $clog2(DIM);
  localparam int CW = $clog2(DIM + 1);
  localparam logic [AW-1:0] LAST = AW'(DIM - 1);

  logic [DIM-1:0][BITS_C-1:0] al_data;
  logic                       v_al;

  // Lane j arrives j cycles late, so it needs DIM-1-j stages to meet lane DIM-1.
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    skew_delay #(.BITS_C(BITS_C), .STAGES(DIM - 1 - j)) u_lane (
      .clk (clk),
      .rst (rst),
      .d_i (in_data[j]),
      .q_o (al_data[j])
    );
  end

  skew_delay #(.BITS_C(1), .STAGES(DIM - 1)) u_valid (
    .clk (clk),
    .rst (rst),
    .d_i (in_valid),
    .q_o (v_al)
  );

  logic [DIM-1:0][BITS_C-1:0] mem_q [DIM];
  logic [AW-1:0]              tag_q [DIM];
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]              wr_row_q, wr_row_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       done_q, done_d, ovf_q, ovf_d;
  logic                       full, pop, wr_en;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == CW'(DIM));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en     = v_al & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_row_d = wr_row_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    done_d   = pop && (tag_q[rd_ptr_q] == LAST);
    if (v_al)  wr_row_d = wrap_inc(wr_row_q);
    if (wr_en) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (pop)   rd_ptr_d = wrap_inc(rd_ptr_q);
    if (v_al && full && !pop) ovf_d = 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_row_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_row_q <= wr_row_d;
      count_q  <= count_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_ptr_q] <= al_data;
      tag_q[wr_ptr_q] <= wr_row_q;
    end
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_row  = out_valid ? tag_q[rd_ptr_q] : '0;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_memc_deskew.sv
// tb/tb_memc_deskew.sv - scoreboard bench for the row deskew and readback FIFO
module tb_memc_deskew;
  import mm_pkg::*;

  localparam int DIM    = MM_DIM;
  localparam int BITS_C = MM_BITS_C;
  localparam int LAT    = DIM;

  typedef struct { row_t data; row_idx_t row; int cyc; } obs_t;
  typedef struct { row_t data; row_idx_t row; } exp_t;

  logic     clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  row_t     in_data = '0;
  logic     out_valid, done, overflow;
  row_t     out_data;
  row_idx_t out_row;

  memc_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  obs_t mon_o;
  obs_t obs[$];
  int   done_cyc[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        mon_o.data = out_data; mon_o.row = out_row; mon_o.cyc = cyc;
        obs.push_back(mon_o);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  exp_t     exp_q[$];
  row_t     hist [DIM];
  logic     hv   [DIM];
  row_idx_t tb_row = '0;
  int       vec = 0, err = 0, obs_rd = 0, done_rd = 0;

  function automatic row_t mk(input int base, input int step);
    row_t r;
    for (int j = 0; j < DIM; j++) r[j] = BITS_C'(base + step * j);
    return r;
  endfunction

  // One cycle of stimulus: row r enters lane 0 now, older rows continue on later lanes.
  task automatic drive(input logic v, input row_t r, input logic keep);
    exp_t e;
    @(posedge clk); #1;
    for (int k = DIM - 1; k > 0; k--) begin hist[k] = hist[k-1]; hv[k] = hv[k-1]; end
    hist[0] = r; hv[0] = v;
    in_valid = v;
    for (int j = 0; j < DIM; j++) in_data[j] = hv[j] ? hist[j][j] : BITS_C'('h555);
    if (v) begin
      if (keep) begin e.data = r; e.row = tb_row; exp_q.push_back(e); end
      tb_row = tb_row + 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    idle(n);
    rst = 0;
    exp_q.delete();
    tb_row  = '0;
    obs_rd  = obs.size();
    done_rd = done_cyc.size();
  endtask

  task automatic test_reset();
    out_ready = 0;
    do_reset(2);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) out_ready = 1;
      @(negedge clk);
      vec++;
      if (out_valid !== 1'b0 || out_row !== '0 || done !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin
        err++;
        $display("FAIL reset_idle: valid=%b row=%0d done=%b ovf=%b data=%h, expected all zero",
                 out_valid, out_row, done, overflow, out_data);
      end
      idle(1);
    end
    out_ready = 0;
  endtask

  task automatic test_single();
    exp_t e; obs_t o; int t_in, first;
    do_reset(2);
    out_ready = 1;
    drive(1'b1, mk(100, 1), 1'b1);
    t_in = cyc; first = -1;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clk);
      if (out_valid && first < 0) first = cyc;
      idle(1);
    end
    vec++;
    if (first !== t_in + LAT) begin
      err++; $display("FAIL single_latency: out_valid first at cycle %0d, expected %0d", first, t_in + LAT);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_rd >= obs.size()) begin
        err++; $display("FAIL single_missing: got nothing, expected row %0d data %h", e.row, e.data);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o.data !== e.data || o.row !== e.row) begin
          err++; $display("FAIL single_row: got row %0d data %h, expected row %0d data %h", o.row, o.data, e.row, e.data);
        end
      end
    end
    vec++;
    if (done_cyc.size() != done_rd) begin
      err++; $display("FAIL single_done: %0d done pulses, expected 0", done_cyc.size() - done_rd);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t o; int t0, s;
    do_reset(2);
    out_ready = 1;
    for (int r = 0; r < DIM; r++) begin
      drive(1'b1, mk(16 * r, 1), 1'b1);
      if (r == 0) t0 = cyc;
    end
    idle(LAT + 6);
    s = obs_rd;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_rd >= obs.size()) begin
        err++; $display("FAIL b2b_missing: got nothing, expected row %0d data %h", e.row, e.data);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o.data !== e.data || o.row !== e.row) begin
          err++; $display("FAIL b2b_row: got row %0d data %h, expected row %0d data %h", o.row, o.data, e.row, e.data);
        end
      end
    end
    for (int k = 0; k < DIM && s + k < obs.size(); k++) begin
      vec++;
      if (obs[s + k].cyc != t0 + LAT + k) begin
        err++; $display("FAIL b2b_timing: row %0d read at cycle %0d, expected %0d", k, obs[s + k].cyc, t0 + LAT + k);
      end
    end
    vec++;
    if (done_cyc.size() - done_rd != 1) begin
      err++; $display("FAIL b2b_done_count: %0d done pulses, expected 1", done_cyc.size() - done_rd);
    end else begin
      vec++;
      if (done_cyc[done_rd] != t0 + LAT + DIM) begin
        err++; $display("FAIL b2b_done_cycle: done at cycle %0d, expected %0d", done_cyc[done_rd], t0 + LAT + DIM);
      end
    end
    done_rd = done_cyc.size();
  endtask

  task automatic test_backpressure();
    exp_t e; obs_t o;
    do_reset(2);
    out_ready = 0;
    for (int r = 0; r < DIM; r++) drive(1'b1, mk(-(8 * r) - 1, -1), 1'b1);
    idle(LAT + 4);
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b1 || overflow !== 1'b0) begin
      err++; $display("FAIL bp_full: valid=%b ovf=%b, expected valid=1 ovf=0", out_valid, overflow);
    end
    out_ready = 1;
    idle(DIM + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_rd >= obs.size()) begin
        err++; $display("FAIL bp_missing: got nothing, expected row %0d data %h", e.row, e.data);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o.data !== e.data || o.row !== e.row) begin
          err++; $display("FAIL bp_row: got row %0d data %h, expected row %0d data %h", o.row, o.data, e.row, e.data);
        end
      end
    end
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b0 || obs_rd != obs.size()) begin
      err++; $display("FAIL bp_drained: valid=%b extra_rows=%0d, expected valid=0 extra_rows=0", out_valid, obs.size() - obs_rd);
    end
  endtask

  task automatic test_overflow();
    exp_t e; obs_t o; int t0; logic exp_ovf; row_t r;
    do_reset(2);
    out_ready = 0;
    for (int k = 0; k <= DIM; k++) begin
      for (int j = 0; j < DIM; j++) r[j] = BITS_C'($urandom);
      drive(1'b1, r, k < DIM);
      if (k == 0) t0 = cyc;
    end
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      exp_ovf = (cyc >= t0 + DIM + LAT);
      vec++;
      if (overflow !== exp_ovf) begin
        err++; $display("FAIL ovf_flag: cycle %0d overflow=%b, expected %b", cyc - t0, overflow, exp_ovf);
      end
      idle(1);
    end
    out_ready = 1;
    idle(DIM + 4);
    drive(1'b1, mk(4242, 7), 1'b1);
    idle(LAT + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_rd >= obs.size()) begin
        err++; $display("FAIL ovf_missing: got nothing, expected row %0d data %h", e.row, e.data);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o.data !== e.data || o.row !== e.row) begin
          err++; $display("FAIL ovf_row: got row %0d data %h, expected row %0d data %h", o.row, o.data, e.row, e.data);
        end
      end
    end
    @(negedge clk);
    vec++;
    if (overflow !== 1'b1 || obs_rd != obs.size()) begin
      err++; $display("FAIL ovf_sticky: ovf=%b extra_rows=%0d, expected ovf=1 extra_rows=0", overflow, obs.size() - obs_rd);
    end
    out_ready = 0;
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o;
    do_reset(2);
    out_ready = 1;
    for (int r = 0; r < 3; r++) drive(1'b1, mk(500 + 10 * r, 1), 1'b0);
    idle(1);
    do_reset(2);
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      err++; $display("FAIL midrst_clear: valid=%b ovf=%b, expected 0 0", out_valid, overflow);
    end
    drive(1'b1, mk(-7, 3), 1'b1);
    idle(LAT + 8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_rd >= obs.size()) begin
        err++; $display("FAIL midrst_missing: got nothing, expected row %0d data %h", e.row, e.data);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o.data !== e.data || o.row !== e.row) begin
          err++; $display("FAIL midrst_row: got row %0d data %h, expected row %0d data %h", o.row, o.data, e.row, e.data);
        end
      end
    end
    vec++;
    if (obs_rd != obs.size()) begin
      err++; $display("FAIL midrst_stale: %0d extra rows read, expected 0", obs.size() - obs_rd);
    end
  endtask

  initial begin
    for (int k = 0; k < DIM; k++) begin hist[k] = '0; hv[k] = 1'b0; end
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
